riscv_exc_controller: RTL and testbench

// Exception/interrupt arbiter feeding the CSR block and the core controller. It samples interrupt lines and

---
 rtl/riscv_exc_controller.sv | 169 ++++++++++++++++
 tb/tb_riscv_exc_controller.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_exc_controller.sv
// Exception/interrupt arbiter: picks the highest-priority synchronous exception or enabled
// interrupt, requests the controller with req/ack, then strobes the cause into mcause.
module riscv_exc_controller #(
  parameter int N_IRQ    = 32,
  parameter int SYNC_IRQ = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IRQ-1:0] irq_i,
  input  logic             irq_enable_i,
  input  logic             illegal_insn_i,
  input  logic             ecall_insn_i,
  input  logic             lsu_load_err_i,
  input  logic             lsu_store_err_i,
  input  logic             ack_i,
  output logic             req_o,
  output logic             is_irq_o,
  output logic [4:0]       irq_id_o,
  output logic [5:0]       cause_o,
  output logic             save_cause_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    SAVE     = 2'd2
  } state_e;

  localparam logic [4:0] CODE_ILLEGAL   = 5'h02;
  localparam logic [4:0] CODE_ECALL     = 5'h0B;
  localparam logic [4:0] CODE_LOAD_ERR  = 5'h05;
  localparam logic [4:0] CODE_STORE_ERR = 5'h07;

  // Lowest set index wins; scanning downwards lets the lowest index overwrite last.
  function automatic logic [4:0] lowest_irq(input logic [N_IRQ-1:0] v);
    logic [4:0] idx;
    idx = 5'd0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      idx = v[i] ? 5'(i) : idx;
    end
    return idx;
  endfunction

  function automatic logic [4:0] sync_code(input logic illegal, input logic ecall,
                                           input logic load_err, input logic store_err);
    logic [4:0] code;
    if (illegal) begin
      code = CODE_ILLEGAL;
    end else if (ecall) begin
      code = CODE_ECALL;
    end else if (load_err) begin
      code = CODE_LOAD_ERR;
    end else if (store_err) begin
      code = CODE_STORE_ERR;
    end else begin
      code = 5'h00;
    end
    return code;
  endfunction

  state_e           state_r, state_nxt_s;
  logic [N_IRQ-1:0] irq_s;
  logic [31:0]      irq_ext_s;
  logic             exc_any_s, irq_any_s, irq_lost_s;
  logic [4:0]       exc_code_s, irq_idx_s;
  logic             load_s, ld_is_irq_s;
  logic [4:0]       ld_code_s;
  logic             req_r, save_r, is_irq_r;
  logic [4:0]       irq_id_r;
  logic [5:0]       cause_r;

  generate
    if (SYNC_IRQ != 0) begin : g_sync
      logic [N_IRQ-1:0] sync1_r, sync2_r;
      // Two-flop synchronizer for the asynchronous interrupt lines
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync1_r <= '0;
          sync2_r <= '0;
        end else begin
          sync1_r <= irq_i;
          sync2_r <= sync1_r;
        end
      end
      assign irq_s = sync2_r;
    end else begin : g_nosync
      assign irq_s = irq_i;
    end
  endgenerate

  assign irq_ext_s  = 32'(irq_s);
  assign exc_any_s  = illegal_insn_i | ecall_insn_i | lsu_load_err_i | lsu_store_err_i;
  assign exc_code_s = sync_code(illegal_insn_i, ecall_insn_i, lsu_load_err_i, lsu_store_err_i);
  assign irq_any_s  = irq_enable_i & (|irq_s);
  assign irq_idx_s  = lowest_irq(irq_s);
  // A latched interrupt is withdrawn when its own line drops or interrupts get disabled.
  assign irq_lost_s = ~irq_ext_s[irq_id_r] | ~irq_enable_i;

  // Next-state and latch-select logic
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    ld_is_irq_s = 1'b0;
    ld_code_s   = 5'h00;
    case (state_r)
      IDLE: begin
        if (exc_any_s) begin
          load_s      = 1'b1;
          ld_code_s   = exc_code_s;
          state_nxt_s = WAIT_ACK;
        end else if (irq_any_s) begin
          load_s      = 1'b1;
          ld_is_irq_s = 1'b1;
          ld_code_s   = irq_idx_s;
          state_nxt_s = WAIT_ACK;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT_ACK: begin
        if (ack_i) begin
          state_nxt_s = SAVE;
        end else if (is_irq_r && exc_any_s) begin
          load_s      = 1'b1;
          ld_code_s   = exc_code_s;
          state_nxt_s = WAIT_ACK;
        end else if (is_irq_r && irq_lost_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WAIT_ACK;
        end
      end
      SAVE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, handshake outputs and latched cause registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      req_r    <= 1'b0;
      save_r   <= 1'b0;
      is_irq_r <= 1'b0;
      irq_id_r <= 5'd0;
      cause_r  <= 6'h00;
    end else begin
      state_r <= state_nxt_s;
      req_r   <= (state_nxt_s == WAIT_ACK);
      save_r  <= (state_nxt_s == SAVE);
      if (load_s) begin
        is_irq_r <= ld_is_irq_s;
        irq_id_r <= ld_is_irq_s ? ld_code_s : 5'd0;
        cause_r  <= {ld_is_irq_s, ld_code_s};
      end
    end
  end

  assign req_o        = req_r;
  assign save_cause_o = save_r;
  assign is_irq_o     = is_irq_r;
  assign irq_id_o     = irq_id_r;
  assign cause_o      = cause_r;

endmodule

// File: tb/tb_riscv_exc_controller.sv
// Self-checking bench for riscv_exc_controller: vector table, directed handshake corner
// cases, and a randomized run against a behavioural reference model.
module tb_riscv_exc_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] irq_v = 32'h0;
  logic        en_v = 1'b0;
  logic [3:0]  flags_v = 4'h0;  // {illegal, ecall, load_err, store_err}
  logic        ack_v = 1'b0;
  logic        req, is_irq, save;
  logic [4:0]  irq_id;
  logic [5:0]  cause;

  int errors = 0;
  int checks = 0;

  riscv_exc_controller #(.N_IRQ(32), .SYNC_IRQ(1)) dut (
    .clk(clk), .rst_n(rst_n), .irq_i(irq_v), .irq_enable_i(en_v),
    .illegal_insn_i(flags_v[3]), .ecall_insn_i(flags_v[2]),
    .lsu_load_err_i(flags_v[1]), .lsu_store_err_i(flags_v[0]),
    .ack_i(ack_v), .req_o(req), .is_irq_o(is_irq), .irq_id_o(irq_id),
    .cause_o(cause), .save_cause_o(save)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] irq, input logic en, input logic [3:0] f, input logic ack);
    irq_v = irq; en_v = en; flags_v = f; ack_v = ack;
  endtask

  // Reference model: a pending event plus the phase of the handshake it is in.
  int          m_phase;  // 0 nothing pending, 1 requesting, 2 saving
  logic        m_isirq;
  logic [4:0]  m_id;
  logic [5:0]  m_cause;
  logic [31:0] m_sync1, m_irqs;

  function automatic int exc_cause(input logic [3:0] f);
    if (f[3]) return 2;
    if (f[2]) return 11;
    if (f[1]) return 5;
    if (f[0]) return 7;
    return -1;
  endfunction

  function automatic int first_irq(input logic [31:0] v);
    for (int i = 0; i < 32; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_isirq = 1'b0; m_id = 5'd0; m_cause = 6'h00;
    m_sync1 = 32'h0; m_irqs = 32'h0;
  endtask

  task automatic model_take(input int c, input logic irq_evt);
    m_isirq = irq_evt;
    m_id    = irq_evt ? 5'(c) : 5'd0;
    m_cause = irq_evt ? 6'(32 + c) : 6'(c);
  endtask

  task automatic model_step();
    int sc, ic;
    sc = exc_cause(flags_v);
    ic = en_v ? first_irq(m_irqs) : -1;
    if (m_phase == 0) begin
      if (sc >= 0) begin model_take(sc, 1'b0); m_phase = 1; end
      else if (ic >= 0) begin model_take(ic, 1'b1); m_phase = 1; end
    end else if (m_phase == 1) begin
      if (ack_v) m_phase = 2;
      else if (m_isirq && sc >= 0) model_take(sc, 1'b0);
      else if (m_isirq && (!m_irqs[m_id] || !en_v)) m_phase = 0;
    end else begin
      m_phase = 0;
    end
    m_irqs  = m_sync1;
    m_sync1 = irq_v;
  endtask

  typedef struct {
    logic [31:0] irq;
    logic        en;
    logic [3:0]  flags;
    logic [5:0]  cause;
    logic [4:0]  id;
    logic        is_irq;
    int          lat;
  } vec_t;

  vec_t tbl[9];

  task automatic do_reset();
    drive(32'h0, 1'b0, 4'h0, 1'b0);
    rst_n = 1'b0;
    model_reset();
    tick(); tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int n, pulses;
    logic [3:0] rf;
    logic clr;

    tbl[0] = '{32'h0,         1'b1, 4'b1100, 6'h02, 5'd0,  1'b0, 1};
    tbl[1] = '{32'h0,         1'b1, 4'b0110, 6'h0B, 5'd0,  1'b0, 1};
    tbl[2] = '{32'h0,         1'b1, 4'b0011, 6'h05, 5'd0,  1'b0, 1};
    tbl[3] = '{32'h0,         1'b0, 4'b0001, 6'h07, 5'd0,  1'b0, 1};
    tbl[4] = '{32'h0000_0030, 1'b1, 4'b0000, 6'h24, 5'd4,  1'b1, 3};
    tbl[5] = '{32'h8000_0000, 1'b1, 4'b0000, 6'h3F, 5'd31, 1'b1, 3};
    tbl[6] = '{32'h0000_0001, 1'b1, 4'b0000, 6'h20, 5'd0,  1'b1, 3};
    tbl[7] = '{32'h0000_0002, 1'b1, 4'b0001, 6'h07, 5'd0,  1'b0, 1};
    tbl[8] = '{32'hFFFF_FFFF, 1'b1, 4'b1111, 6'h02, 5'd0,  1'b0, 1};

    do_reset();
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_req", req, 1'b0);
      check("idle_save", save, 1'b0);
      check("idle_cause", cause, 6'h00);
    end

    // Table: raise, wait for req with a bound, ack (dropping the sources), check strobe.
    foreach (tbl[i]) begin
      drive(tbl[i].irq, tbl[i].en, tbl[i].flags, 1'b0);
      n = 0;
      do begin tick(); n++; end while (!req && n < 6);
      check($sformatf("tbl%0d_req", i), req, 1'b1);
      check($sformatf("tbl%0d_lat", i), n, tbl[i].lat);
      check($sformatf("tbl%0d_cause", i), cause, tbl[i].cause);
      check($sformatf("tbl%0d_isirq", i), is_irq, tbl[i].is_irq);
      check($sformatf("tbl%0d_id", i), irq_id, tbl[i].id);
      drive(32'h0, tbl[i].en, 4'h0, 1'b1);
      tick();
      check($sformatf("tbl%0d_save", i), save, 1'b1);
      check($sformatf("tbl%0d_req_low", i), req, 1'b0);
      check($sformatf("tbl%0d_save_cause", i), cause, tbl[i].cause);
      ack_v = 1'b0;
      tick();
      check($sformatf("tbl%0d_save_end", i), save, 1'b0);
      tick(); tick();
      check($sformatf("tbl%0d_quiet", i), req, 1'b0);
    end

    // Interrupt masked by the enable, then accepted one edge after enabling.
    drive(32'h0000_0010, 1'b0, 4'h0, 1'b0);
    repeat (5) tick();
    check("masked_req", req, 1'b0);
    en_v = 1'b1;
    tick();
    check("unmask_req", req, 1'b1);
    check("unmask_cause", cause, 6'h24);
    drive(32'h0, 1'b1, 4'h0, 1'b1);
    tick(); ack_v = 1'b0; tick(); tick(); tick();

    // Two-flop latency: request after k+2, ack at k+4.
    drive(32'h0000_0030, 1'b1, 4'h0, 1'b0);
    tick(); check("lat_k", req, 1'b0);
    tick(); check("lat_k1", req, 1'b0);
    tick(); check("lat_k2", req, 1'b1);
    check("lat_cause", cause, 6'h24);
    check("lat_id", irq_id, 5'd4);
    tick(); check("lat_k3", req, 1'b1);
    drive(32'h0, 1'b1, 4'h0, 1'b1);
    tick(); check("lat_save", save, 1'b1); check("lat_save_req", req, 1'b0);
    ack_v = 1'b0;
    tick(); check("lat_save_one", save, 1'b0);
    tick(); tick();

    // Illegal and ecall together: illegal wins, one strobe.
    drive(32'h0, 1'b1, 4'b1100, 1'b0);
    tick(); tick(); tick();
    check("dual_cause", cause, 6'h02);
    check("dual_isirq", is_irq, 1'b0);
    drive(32'h0, 1'b1, 4'h0, 1'b1);
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      ack_v = 1'b0;
      if (save) pulses++;
    end
    check("dual_pulses", pulses, 1);

    // Preemption of irq 3 by a store error, req held high.
    drive(32'h0000_0008, 1'b1, 4'h0, 1'b0);
    tick(); tick(); tick();
    check("pre_irq_cause", cause, 6'h23);
    tick();
    flags_v = 4'b0001;
    tick();
    check("pre_req", req, 1'b1);
    check("pre_cause", cause, 6'h07);
    check("pre_isirq", is_irq, 1'b0);
    check("pre_id", irq_id, 5'd0);
    tick();
    check("pre_req_hold", req, 1'b1);
    drive(32'h0, 1'b1, 4'h0, 1'b1);
    tick(); check("pre_save", save, 1'b1); check("pre_save_cause", cause, 6'h07);
    ack_v = 1'b0;
    tick(); tick(); tick();

    // Cancel: irq 1 latched, enable drops without ack.
    drive(32'h0000_0002, 1'b1, 4'h0, 1'b0);
    tick(); tick(); tick();
    check("cxl_req", req, 1'b1);
    en_v = 1'b0;
    tick();
    check("cxl_req_low", req, 1'b0);
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (save || req) pulses++;
    end
    check("cxl_no_save", pulses, 0);
    irq_v = 32'h0;
    tick(); tick(); tick();

    // Same, but ack arrives in the drop cycle: ack wins.
    drive(32'h0000_0002, 1'b1, 4'h0, 1'b0);
    tick(); tick(); tick();
    drive(32'h0, 1'b0, 4'h0, 1'b1);
    tick();
    check("cxlack_save", save, 1'b1);
    check("cxlack_cause", cause, 6'h21);
    ack_v = 1'b0;
    tick(); check("cxlack_end", save, 1'b0);
    tick(); tick();

    // Asynchronous reset while the strobe is high.
    drive(32'h0, 1'b1, 4'b1000, 1'b0);
    tick();
    drive(32'h0, 1'b1, 4'h0, 1'b1);
    tick();
    check("rst_pre_save", save, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_save", save, 1'b0);
    check("rst_req", req, 1'b0);
    check("rst_cause", cause, 6'h00);
    ack_v = 1'b0;
    model_reset();
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_rel_req", req, 1'b0);
    check("rst_rel_save", save, 1'b0);
    check("rst_rel_cause", cause, 6'h00);

    // Randomized run against the reference model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      case ($urandom_range(0, 7))
        0: irq_v = 32'h1 << $urandom_range(0, 31);
        1: irq_v = 32'h0;
        2: irq_v = $urandom & $urandom & $urandom;
        default: irq_v = irq_v;
      endcase
      if ($urandom_range(0, 9) == 0) en_v = ~en_v;
      if (flags_v == 4'h0 && $urandom_range(0, 11) == 0) begin
        rf = 4'($urandom_range(1, 15));
        flags_v = rf;
      end
      ack_v = ($urandom_range(0, 2) == 0);
      clr = (m_phase == 1) && ack_v && !m_isirq;
      model_step();
      tick();
      check("rnd_req", req, (m_phase == 1));
      check("rnd_save", save, (m_phase == 2));
      check("rnd_cause", cause, m_cause);
      check("rnd_isirq", is_irq, m_isirq);
      check("rnd_id", irq_id, m_id);
      if (clr) flags_v = 4'h0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
